// File: rtl/urna_votacion_pkg.sv
// Shared definitions for the ballot-box stage: state encoding, defaults and
// the majority helper used by the voter sub-module.
package urna_votacion_pkg;

  // Round FSM encoding: IDLE=0, OPEN=1, EVAL=2.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_EVAL = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 100;
  localparam int DEFAULT_CW      = 8;

  // Two-out-of-three majority.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/urna_votacion_votador.sv
// Combinational majority voter: v is 1 when at least two of a, b, c are 1.
module votador
  import urna_votacion_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic v
);

  assign v = majority3(a, b, c);

endmodule

// File: rtl/urna_votacion.sv
// Ballot-box stage ahead of the majority voter. Opens a round on start,
// captures the first vote of each of three voters, closes the round when all
// have voted or the round timer expires, then registers the verdict with a
// one-cycle done pulse and keeps saturating yes/no round tallies.
//
// Handshake: there is no backpressure. start is a request sampled only while
// idle; vote_en[i] qualifies vote_val[i] on the same edge and is only honoured
// while the round is open and voter i has not yet voted. done is a single-cycle
// valid strobe for result; result holds until the next done.
module urna_votacion
  import urna_votacion_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CW      = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [2:0]    vote_en,
  input  logic [2:0]    vote_val,
  output logic          busy,
  output logic [2:0]    voted,
  output logic          done,
  output logic          result,
  output logic [CW-1:0] yes_count,
  output logic [CW-1:0] no_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Timer value seen on the last open cycle of a round.
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next_state;
  logic [2:0]      r_voted;
  logic [2:0]      r_votes;
  logic [TW-1:0]   r_timer;
  logic            r_done;
  logic            r_result;
  logic [CW-1:0]   r_yes;
  logic [CW-1:0]   r_no;
  logic [2:0]      w_new_vote;
  logic [2:0]      w_voted_upd;
  logic            w_verdict;

  // Voters casting their first vote this cycle; repeats are masked out.
  assign w_new_vote  = vote_en & ~r_voted;
  assign w_voted_upd = r_voted | vote_en;

  // Next-state logic: close on a full ballot (including this edge's votes) or expiry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_OPEN;
      S_OPEN: if ((w_voted_upd == 3'b111) || (r_timer == TMAX)) w_next_state = S_EVAL;
      S_EVAL: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Ballot capture: clear on round start, latch first votes and run the timer while open.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_voted <= '0;
      r_votes <= '0;
      r_timer <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_voted <= '0;
            r_votes <= '0;
            r_timer <= '0;
          end
        end
        S_OPEN: begin
          r_voted <= w_voted_upd;
          r_votes <= (r_votes & ~w_new_vote) | (vote_val & w_new_vote);
          r_timer <= r_timer + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Missing votes stay 0 in r_votes and therefore count as "no".
  votador u_votador (
    .v (w_verdict),
    .a (r_votes[0]),
    .b (r_votes[1]),
    .c (r_votes[2])
  );

  // Verdict register, done strobe and saturating tallies, updated on leaving EVAL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done   <= 1'b0;
      r_result <= 1'b0;
      r_yes    <= '0;
      r_no     <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_EVAL) begin
        r_done   <= 1'b1;
        r_result <= w_verdict;
        if (w_verdict) begin
          if (r_yes != '1) r_yes <= r_yes + 1'b1;
        end else begin
          if (r_no != '1) r_no <= r_no + 1'b1;
        end
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign voted     = r_voted;
  assign done      = r_done;
  assign result    = r_result;
  assign yes_count = r_yes;
  assign no_count  = r_no;

endmodule

// File: tb/tb_urna_votacion.sv
// Bench for urna_votacion with a short timeout and narrow tallies so that
// expiry and saturation are reached quickly.
module tb_urna_votacion;

  localparam int TIMEOUT_T = 8;
  localparam int CW_T      = 2;
  localparam int MAXC      = (1 << CW_T) - 1;

  logic            clk;
  logic            reset_n;
  logic            start;
  logic [2:0]      vote_en;
  logic [2:0]      vote_val;
  logic            busy;
  logic [2:0]      voted;
  logic            done;
  logic            result;
  logic [CW_T-1:0] yes_count;
  logic [CW_T-1:0] no_count;

  urna_votacion #(.TIMEOUT(TIMEOUT_T), .CW(CW_T)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .vote_en   (vote_en),
    .vote_val  (vote_val),
    .busy      (busy),
    .voted     (voted),
    .done      (done),
    .result    (result),
    .yes_count (yes_count),
    .no_count  (no_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks;
  int errors;
  int model_yes;
  int model_no;
  bit pending_start;
  logic [3:0] exp_q[$];   // {voted[2:0], result} per closed round
  logic [2:0] en_q[$];
  logic [2:0] val_q[$];
  bit         st_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_voted"}, voted, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_yes"}, yes_count, 0);
    check({tag, "_no"}, no_count, 0);
  endtask

  task automatic model_reset();
    model_yes = 0;
    model_no = 0;
    pending_start = 0;
    exp_q.delete();
  endtask

  // ---------------- driver: one full round ----------------
  // Per-cycle stimulus for the open cycles comes from en_q/val_q/st_q; the
  // reference model records the first vote of each voter and decides the
  // closing cycle from the round rules.
  task automatic run_round(input bit chain, output logic o_res, output logic [2:0] o_vot,
                           output int o_edges);
    bit mv[3];
    bit mval[3];
    int close_c;
    int c;
    int n_yes;
    logic [2:0] e;
    logic [2:0] v;
    bit s;
    logic [3:0] item;
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0;
      mval[i] = 0;
    end
    if (!pending_start) begin
      @(negedge clk);
      start = 1'b1;
    end
    pending_start = 0;
    @(negedge clk);
    start = 1'b0;
    check("open_busy", busy, 1);
    check("open_voted_clear", voted, 0);
    check("open_done_low", done, 0);
    close_c = -1;
    c = 0;
    o_edges = 0;
    while (o_edges < TIMEOUT_T + 4) begin
      e = (en_q.size() > 0) ? en_q.pop_front() : 3'b000;
      v = (val_q.size() > 0) ? val_q.pop_front() : 3'b000;
      s = (st_q.size() > 0) ? st_q.pop_front() : 1'b0;
      vote_en = e;
      vote_val = v;
      start = s;
      if (close_c < 0) begin
        for (int i = 0; i < 3; i++) begin
          if (e[i] && !mv[i]) begin
            mv[i] = 1;
            mval[i] = v[i];
          end
        end
        if ((mv[0] && mv[1] && mv[2]) || (c == TIMEOUT_T - 1)) begin
          close_c = c;
          n_yes = int'(mval[0]) + int'(mval[1]) + int'(mval[2]);
          exp_q.push_back({mv[2], mv[1], mv[0], (n_yes >= 2) ? 1'b1 : 1'b0});
        end
      end
      @(negedge clk);
      o_edges++;
      c++;
      if (done === 1'b1) break;
      check("round_busy", busy, 1);
    end
    vote_en = 3'b000;
    vote_val = 3'b000;
    start = 1'b0;
    en_q.delete();
    val_q.delete();
    st_q.delete();
    check("done_seen", done, 1);
    check("latency", o_edges, close_c + 2);
    check("idle_after_done", busy, 0);
    if (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      check("result", result, item[0]);
      check("voted", voted, item[3:1]);
      if (item[0]) model_yes = (model_yes < MAXC) ? model_yes + 1 : model_yes;
      else         model_no  = (model_no  < MAXC) ? model_no  + 1 : model_no;
    end else begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got done with no expected round, required a closed round");
    end
    check("yes_count", yes_count, model_yes);
    check("no_count", no_count, model_no);
    o_res = result;
    o_vot = voted;
    if (chain) begin
      start = 1'b1;
      pending_start = 1;
    end else begin
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("voted_held", voted, o_vot);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [8:0] en;       // {cycle2, cycle1, cycle0}
    logic [8:0] val;
    logic [2:0] st;       // start asserted during open cycle n
    logic       exp_res;
    logic [2:0] exp_vot;
    int         exp_edges;
  } vec_t;

  vec_t vecs[6];

  logic       r_res;
  logic [2:0] r_vot;
  int         r_edges;

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    start = 1'b0;
    vote_en = 3'b000;
    vote_val = 3'b000;
    model_reset();

    // normal round, duplicate vote, timeout, simultaneous with start during
    // open, timeout with ignored duplicate, late votes with start during open
    vecs[0] = '{9'b100_010_001, 9'b000_010_001, 3'b000, 1'b1, 3'b111, 4};
    vecs[1] = '{9'b110_001_001, 9'b110_001_000, 3'b000, 1'b1, 3'b111, 4};
    vecs[2] = '{9'b000_000_100, 9'b000_000_100, 3'b000, 1'b0, 3'b100, 9};
    vecs[3] = '{9'b000_000_111, 9'b000_000_011, 3'b001, 1'b1, 3'b111, 2};
    vecs[4] = '{9'b000_010_011, 9'b000_010_001, 3'b000, 1'b0, 3'b011, 9};
    vecs[5] = '{9'b000_101_000, 9'b000_101_000, 3'b010, 1'b1, 3'b101, 9};

    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 3; c++) begin
        en_q.push_back(vecs[k].en[c*3 +: 3]);
        val_q.push_back(vecs[k].val[c*3 +: 3]);
        st_q.push_back(vecs[k].st[c]);
      end
      run_round(1'b0, r_res, r_vot, r_edges);
      check($sformatf("vec%0d_result", k), r_res, vecs[k].exp_res);
      check($sformatf("vec%0d_voted", k), r_vot, vecs[k].exp_vot);
      check($sformatf("vec%0d_edges", k), r_edges, vecs[k].exp_edges);
    end

    // asynchronous reset in the middle of an open round
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vote_en = 3'b011;
    vote_val = 3'b011;
    @(negedge clk);
    vote_en = 3'b000;
    vote_val = 3'b000;
    @(posedge clk);
    #($urandom_range(1, 8));
    reset_n = 1'b0;
    #1;
    check_all_zero("midround_reset");
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_done_after_reset", done, 0);
      check("idle_after_reset", busy, 0);
    end

    // back-to-back yes rounds into tally saturation
    for (int r = 0; r < 5; r++) begin
      if (r % 2 == 0) begin
        en_q.push_back(3'b111);
        val_q.push_back(3'b111);
      end else begin
        en_q.push_back(3'b001); val_q.push_back(3'b001);
        en_q.push_back(3'b100); val_q.push_back(3'b100);
        en_q.push_back(3'b010); val_q.push_back(3'b000);
      end
      run_round(r < 4, r_res, r_vot, r_edges);
      if (r >= 3) check($sformatf("sat_yes_round%0d", r + 1), yes_count, 3);
    end
    check("sat_no", no_count, 0);

    // randomized rounds against the reference model
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < TIMEOUT_T; c++) begin
        en_q.push_back(($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
        val_q.push_back(3'($urandom_range(0, 7)));
        st_q.push_back($urandom_range(0, 4) == 0);
      end
      run_round((r < 39) && ($urandom_range(0, 1) == 1), r_res, r_vot, r_edges);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
